// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the iterative divider: operand width,
//                RV32M divide opcode encoding and divider FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int XLEN = 32;

    // Opcode order matches the RV32M funct3[1:0] ordering.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : add_sub
//  Description : Ripple-agnostic adder/subtractor.
//                add=1 : sum = a + b
//                add=0 : sum = a - b (a + ~b + 1); cOut=1 means no borrow.
//  Ports       : a, b   operands (WIDTH bits)
//                add    1 = add, 0 = subtract
//                sum    result (WIDTH bits)
//                cOut   carry out of the MSB
//  Revision    : 1.0  initial release
// ============================================================================
module add_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add,
    output logic [WIDTH-1:0] sum,
    output logic             cOut
);

    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff       = add ? b : ~b;
    assign {cOut, sum}   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, ~add};

endmodule : add_sub
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : RV32M iterative restoring divider (DIV/DIVU/REM/REMU).
//                One quotient bit per cycle on unsigned magnitudes, followed
//                by a single sign fix-up cycle. Divide-by-zero and signed
//                overflow bypass the iteration and finish one cycle after
//                acceptance.
//  Ports       : clk    clock, rising edge
//                reset  synchronous active-high reset
//                start  request, sampled only while idle
//                op     00 DIV, 01 DIVU, 10 REM, 11 REMU
//                a, b   dividend / divisor, captured on accepted start
//                busy   high while iterating or fixing up signs
//                done   one-cycle pulse when q carries a new result
//                q      result, held until the next accepted start completes
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] q
);

    localparam logic [4:0]      c_count_init = 5'(XLEN - 1);
    localparam logic [XLEN-1:0] c_one        = XLEN'(1);
    localparam logic [XLEN-1:0] c_int_min    = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      r_state;
    div_state_e      w_state_nxt;

    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_quo;      // dividend shifts out MSB-first, quotient shifts in
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_q;
    logic [4:0]      r_count;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;

    // ------------------------------------------------------------------
    // Acceptance-time decode
    // ------------------------------------------------------------------
    logic            w_signed;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    assign w_signed   = (div_op_e'(op) == OP_DIV) || (div_op_e'(op) == OP_REM);
    assign w_div_zero = (b == '0);
    assign w_ovf      = w_signed && (a == c_int_min) && (b == '1);
    // Negating INT_MIN yields 32'h80000000, which is the correct unsigned magnitude.
    assign w_a_mag    = (w_signed && a[XLEN-1]) ? (~a + c_one) : a;
    assign w_b_mag    = (w_signed && b[XLEN-1]) ? (~b + c_one) : b;

    // ------------------------------------------------------------------
    // Trial subtraction. The shifted partial remainder can reach 2*divisor-1,
    // so the subtractor is one bit wider than the datapath.
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_trial_a;
    logic [XLEN:0]   w_trial_b;
    logic [XLEN:0]   w_diff;
    logic            w_no_borrow;
    logic [XLEN-1:0] w_rem_nxt;
    logic            w_unused_diff_msb;

    assign w_trial_a = {r_rem, r_quo[XLEN-1]};
    assign w_trial_b = {1'b0, r_divisor};

    add_sub #(
        .WIDTH (XLEN + 1)
    ) u_add_sub (
        .a    (w_trial_a),
        .b    (w_trial_b),
        .add  (1'b0),
        .sum  (w_diff),
        .cOut (w_no_borrow)
    );

    // Both kept values are below the divisor, so their MSB is always zero.
    assign w_rem_nxt         = w_no_borrow ? w_diff[XLEN-1:0] : w_trial_a[XLEN-1:0];
    assign w_unused_diff_msb = w_diff[XLEN];

    // ------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_quo_fix = r_neg_q ? (~r_quo + c_one) : r_quo;
    assign w_rem_fix = r_neg_r ? (~r_rem + c_one) : r_rem;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_div_zero || w_ovf) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_count == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divisor <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_count   <= c_count_init;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_rem  <= op[1];
                        r_neg_q   <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        r_neg_r   <= w_signed && a[XLEN-1];
                        r_divisor <= w_b_mag;
                        r_quo     <= w_a_mag;
                        r_rem     <= '0;
                        r_count   <= c_count_init;
                        if (w_div_zero) begin
                            r_q <= op[1] ? a : '1;
                        end else if (w_ovf) begin
                            r_q <= op[1] ? '0 : c_int_min;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_nxt;
                    r_quo   <= {r_quo[XLEN-2:0], w_no_borrow};
                    r_count <= r_count - 5'd1;
                end
                S_FIX: begin
                    r_q <= r_is_rem ? w_rem_fix : w_quo_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign q = r_q;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit: directed vector table,
//                randomized operations against an arithmetic reference, and
//                hand-written reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

    localparam logic [1:0] c_div  = 2'b00;
    localparam logic [1:0] c_divu = 2'b01;
    localparam logic [1:0] c_rem  = 2'b10;
    localparam logic [1:0] c_remu = 2'b11;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] q;

    int n_pass  = 0;
    int n_total = 0;

    div_unit #(
        .XLEN (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        int          lat;
        int          pulse_at;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32M division semantics in plain arithmetic.
    function automatic logic [31:0] ref_q(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic is_signed = (o == c_div) || (o == c_rem);
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (is_signed && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return (o == c_rem) ? 32'h0 : 32'h8000_0000;
        case (o)
            c_div:   return 32'($signed(x) / $signed(y));
            c_divu:  return x / y;
            c_rem:   return 32'($signed(x) % $signed(y));
            default: return x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic is_signed = (o == c_div) || (o == c_rem);
        if (y == 0) return 1;
        if (is_signed && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issues one operation; cycle N is the period following clock edge N-1,
    // with start sampled at edge 0. Optionally pulses start again at cycle
    // pulse_at, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_q, input int exp_lat, input int pulse_at,
                          input string name);
        int cyc;
        bit busy_bad;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: the running operation must not see them.
        op = 2'($urandom); a = $urandom; b = $urandom;
        cyc = 1;
        busy_bad = 0;
        while (1) begin
            if (busy !== ((exp_lat == 34) && (cyc <= 33))) busy_bad = 1;
            if (cyc == pulse_at) begin
                start = 1'b1; op = c_divu; a = 32'd1; b = 32'd1;
            end
            if (done === 1'b1 || cyc >= 40) break;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check({name, " done_cycle"}, 32'(cyc), 32'(exp_lat));
        check({name, " busy_profile"}, {31'b0, busy_bad}, 32'd0);
        check({name, " q"}, q, exp_q);
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " done_one_cycle"}, {31'b0, done}, 32'd0);
        check({name, " idle_after"}, {31'b0, busy}, 32'd0);
        check({name, " q_held"}, q, exp_q);
    endtask

    initial begin
        vecs[0]  = '{c_divu, 32'd100,        32'd7,          32'd14,         34, 0};
        vecs[1]  = '{c_remu, 32'd100,        32'd7,          32'd2,          34, 0};
        vecs[2]  = '{c_div,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 0};
        vecs[3]  = '{c_rem,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 0};
        vecs[4]  = '{c_divu, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0};
        vecs[5]  = '{c_rem,  32'd5,          32'd0,          32'd5,          1,  0};
        vecs[6]  = '{c_div,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0};
        vecs[7]  = '{c_rem,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1,  0};
        vecs[8]  = '{c_divu, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 10};
        vecs[9]  = '{c_div,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, 0};
        vecs[10] = '{c_rem,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, 0};
        vecs[11] = '{c_div,  32'h8000_0000,  32'd2,          32'hC000_0000,  34, 0};
        vecs[12] = '{c_remu, 32'h8000_0000,  32'd3,          32'd2,          34, 0};
        vecs[13] = '{c_divu, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          34, 34};
        vecs[14] = '{c_rem,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1,  1};
        vecs[15] = '{c_divu, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 0};

        // Reset state, with start asserted alongside reset (reset wins).
        reset = 1'b1; start = 1'b1; op = c_divu; a = 32'd5; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset q", q, 32'd0);
        @(negedge clk);
        start = 1'b0; reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].lat,
                   vecs[i].pulse_at, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = $urandom >> $urandom_range(0, 31);
                4:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, ref_q(ro, ra, rb), ref_lat(ro, ra, rb), 0,
                   $sformatf("rand%0d", i));
        end

        // Reset in the middle of a computation: abort without a done pulse.
        begin
            bit seen_done;
            @(negedge clk);
            start = 1'b1; op = c_divu; a = 32'd100; b = 32'd7;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (14) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk); #1;
            check("midreset busy", {31'b0, busy}, 32'd0);
            check("midreset done", {31'b0, done}, 32'd0);
            check("midreset q", q, 32'd0);
            reset = 1'b0;
            seen_done = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1 || busy === 1'b1) seen_done = 1;
            end
            check("midreset no_activity", {31'b0, seen_done}, 32'd0);
            run_op(c_divu, 32'd9, 32'd3, 32'd3, 34, 0, "after_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-006 a  input  32  dividend; captured when start accepted.
REQ-007 b  input  32  divisor; captured when start accepted.
REQ-008 busy  output  1  high while in CALC or FIX.
REQ-009 done  output  1  one-cycle pulse, result valid on q.
REQ-010 q  output  32  quotient (DIV/DIVU) or remainder (REM/REMU); held until next accepted start.

Function
REQ-011 FSM states IDLE, CALC, FIX, DONE; encoding from shared package.
REQ-012 IDLE: start=1 captures op, |a|, |b| (signed ops take magnitudes), sign flags; next state CALC, or DONE for a special case.
REQ-013 CALC: restoring division, one quotient bit per cycle, MSB first, 32 cycles by 5-bit down-counter from 31.
REQ-014 Each CALC step: partial remainder shifted left by one with next dividend bit, trial-subtract divisor; carry-out=1 (no borrow) keeps difference and sets quotient bit to 1, else restores and sets bit to 0.
REQ-015 Counter reaches 0 in CALC -> FIX; FIX applies signs: quotient negated if sign(a)!=sign(b), remainder takes sign of a; selects quotient or remainder per op; loads q.
REQ-016 FIX -> DONE; DONE asserts done for exactly one cycle, then IDLE unconditionally.
REQ-017 Latency, normal path: start sampled at edge 0; busy=1 cycles 1..33; done=1 cycle 34; q valid from cycle 34.
REQ-018 Divide by zero (b=0, any op): IDLE -> DONE directly; q=32'hFFFFFFFF for DIV/DIVU, q=a for REM/REMU; done in cycle 1, busy never high.
REQ-019 Signed overflow (DIV/REM, a=32'h80000000, b=32'hFFFFFFFF): IDLE -> DONE; q=32'h80000000 for DIV, 0 for REM; done in cycle 1.
REQ-020 start while not in IDLE (CALC, FIX, DONE) ignored; captured operands unchanged.
REQ-021 a, b, op changes after acceptance do not affect the running operation.
REQ-022 Magnitude of 32'h80000000 computed as unsigned 32'h80000000 (no overflow of internal 32-bit unsigned datapath).

Reset
REQ-023 reset=1 at an edge: state IDLE, busy=0, done=0, q=0, counter=31, internal registers 0.
REQ-024 Reset mid-operation (CALC/FIX/DONE) aborts without a done pulse; first start after reset deassertion accepted normally.
REQ-025 Reset has priority over start in the same cycle.

Structure
REQ-026 Shared package div_pkg holds op enum (DIV, DIVU, REM, REMU), state enum, XLEN constant.
REQ-027 Trial subtraction uses one instance of existing add_sub (add=0, cOut=1 means no borrow); no other sub-modules.
REQ-028 Sign fix-up negation by two's complement in FIX, single cycle; no multi-cycle paths.

Verification
REQ-029 DIVU a=100, b=7 -> done cycle 34, q=14; repeat REMU -> q=2.
REQ-030 DIV a=-7 (32'hFFFFFFF9), b=2 -> q=32'hFFFFFFFD (-3); REM same -> q=32'hFFFFFFFF (-1).
REQ-031 DIVU a=5, b=0 -> done cycle 1, q=32'hFFFFFFFF; REM a=5, b=0 -> q=5; busy stays 0.
REQ-032 DIV a=32'h80000000, b=32'hFFFFFFFF -> done cycle 1, q=32'h80000000; REM same -> q=0.
REQ-033 DIVU a=32'hFFFFFFFF, b=1 started; start with a=1, b=1 pulsed at cycle 10 -> ignored, q=32'hFFFFFFFF at cycle 34.
REQ-034 Start DIVU a=100, b=7; reset at cycle 15 -> busy=0, q=0, no done pulse; then DIVU a=9, b=3 -> q=3, 34 cycles after acceptance.
